// File: rtl/char_in_ctrl_if.sv
// Register bus and character-source signals of the character input controller.
// The slave modport is the controller; the master modport is the CPU/source side.
interface char_in_ctrl_if;
   logic        poll;
   logic [7:0]  key_char;
   logic        key_strobe;
   logic        reg_sel;
   logic [1:0]  reg_addr;
   logic        reg_wr;
   logic        reg_rd;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        irq;

   modport master (
      input  poll, reg_rdata, irq,
      output key_char, key_strobe, reg_sel, reg_addr, reg_wr, reg_rd, reg_wdata
   );

   modport slave (
      output poll, reg_rdata, irq,
      input  key_char, key_strobe, reg_sel, reg_addr, reg_wr, reg_rd, reg_wdata
   );
endinterface

// File: rtl/char_in_ctrl.sv
// Character input controller: periodic poll scheduler, strobe-capture FIFO and
// DATA/STATUS/CTRL/PERIOD register file with a level interrupt.
module char_in_ctrl #(
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned DEFAULT_PERIOD = 12000
) (
   input logic           clk,
   input logic           resetn,
   char_in_ctrl_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [1:0] StDisabled = 2'd0;
   localparam logic [1:0] StCount    = 2'd1;
   localparam logic [1:0] StPoll     = 2'd2;
   localparam logic [1:0] StHold     = 2'd3;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          poll_en_q, poll_en_d;
   logic          irq_en_q, irq_en_d;
   logic [31:0]   period_q, period_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [1:0]    state_q, state_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          irq_q, irq_d;

   logic rd_acc, wr_acc, full, empty, pop, push, flush, ovf_set;
   logic ctrl_wr, period_wr, status_wr;
   logic [31:0] status;

   assign rd_acc    = bus.reg_sel & bus.reg_rd;
   assign wr_acc    = bus.reg_sel & bus.reg_wr;
   assign ctrl_wr   = wr_acc && (bus.reg_addr == 2'd2);
   assign period_wr = wr_acc && (bus.reg_addr == 2'd3);
   assign status_wr = wr_acc && (bus.reg_addr == 2'd1);
   assign full      = count_q == (AW+1)'(DEPTH);
   assign empty     = count_q == '0;
   assign pop       = rd_acc && (bus.reg_addr == 2'd0) && !empty;
   assign flush     = ctrl_wr && bus.reg_wdata[2];
   // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
   assign push      = bus.key_strobe && !flush && (!full || pop);
   assign ovf_set   = bus.key_strobe && !flush && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + (AW+1)'(1);
         else if (pop && !push) count_d = count_q - (AW+1)'(1);
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      if (flush)                               overflow_d = 1'b0;
      else if (ovf_set)                        overflow_d = 1'b1;
      else if (status_wr && bus.reg_wdata[2])  overflow_d = 1'b0;
   end

   assign poll_en_d = ctrl_wr ? bus.reg_wdata[0] : poll_en_q;
   assign irq_en_d  = ctrl_wr ? bus.reg_wdata[1] : irq_en_q;
   assign period_d  = !period_wr ? period_q :
                      (bus.reg_wdata == 32'd0) ? 32'd1 : bus.reg_wdata;
   assign irq_d     = irq_en_q & (!empty | overflow_q);

   always_comb begin
      status       = '0;
      status[0]    = !empty;
      status[1]    = full;
      status[2]    = overflow_q;
      status[16:8] = 9'(count_q);
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_acc) begin
         case (bus.reg_addr)
            2'd0:    rdata_d = empty ? 32'd0 : {23'b0, 1'b1, mem[rd_ptr_q]};
            2'd1:    rdata_d = status;
            2'd2:    rdata_d = {29'b0, 1'b0, irq_en_q, poll_en_q};
            default: rdata_d = period_q;
         endcase
      end
   end

   // The enable is taken from the next-state value so the first poll lands PERIOD
   // cycles after the CTRL write edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!poll_en_d) begin
         state_d = StDisabled;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StDisabled: begin
               state_d = StCount;
               cnt_d   = '0;
            end
            StCount: begin
               if (period_wr)                         cnt_d = '0;
               else if (cnt_q == period_q - 32'd1)    state_d = full ? StHold : StPoll;
               else                                   cnt_d = cnt_q + 32'd1;
            end
            StPoll: begin
               state_d = StCount;
               cnt_d   = '0;
            end
            default: begin
               if (period_wr) begin
                  state_d = StCount;
                  cnt_d   = '0;
               end else if (!full) begin
                  state_d = StPoll;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.key_char;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         poll_en_q  <= 1'b0;
         irq_en_q   <= 1'b0;
         period_q   <= 32'(DEFAULT_PERIOD);
         cnt_q      <= '0;
         state_q    <= StDisabled;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         poll_en_q  <= poll_en_d;
         irq_en_q   <= irq_en_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.poll      = state_q == StPoll;
   assign bus.reg_rdata = rdata_q;
   assign bus.irq       = irq_q;
endmodule

// File: tb/tb_char_in_ctrl.sv
// Bench for char_in_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based behavioural model.
module tb_char_in_ctrl;
   localparam int DEPTH = 4;

   logic clk;
   logic resetn;
   char_in_ctrl_if bus ();

   char_in_ctrl #(.DEPTH(DEPTH), .DEFAULT_PERIOD(12000)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   longint edge_no = 0;

   // Behavioural model state.
   logic [7:0]  mq[$];
   bit          m_ovf, m_pen, m_ien, m_irq, m_poll;
   int unsigned m_per;
   logic [31:0] m_rdata;
   longint      m_due;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_no, act, exp);
      end
   endtask

   // Advance the model across the edge numbered e, using pre-edge state.
   task automatic model_edge(input longint e, input logic rn, input logic strb,
                             input logic [7:0] ch, input logic sel, input logic [1:0] addr,
                             input logic wr, input logic rd, input logic [31:0] wd);
      bit rd_acc, wr_acc, full_b, pop, flush, pen_n, per_wr;
      int unsigned per_n;
      logic [31:0] st;
      if (!rn) begin
         mq.delete();
         m_ovf = 0; m_pen = 0; m_ien = 0; m_irq = 0; m_poll = 0;
         m_per = 12000; m_rdata = 0; m_due = -1;
         return;
      end
      rd_acc = sel && rd;
      wr_acc = sel && wr;
      full_b = mq.size() == DEPTH;
      m_irq  = m_ien && (mq.size() != 0 || m_ovf);
      st = {15'b0, 9'(mq.size()), 5'b0, m_ovf, full_b, mq.size() != 0};
      if (rd_acc) begin
         case (addr)
            2'd0: m_rdata = (mq.size() == 0) ? 32'd0 : (32'h100 | 32'(mq[0]));
            2'd1: m_rdata = st;
            2'd2: m_rdata = {30'b0, m_ien, m_pen};
            default: m_rdata = m_per;
         endcase
      end
      pen_n  = (wr_acc && addr == 2'd2) ? wd[0] : m_pen;
      per_wr = wr_acc && addr == 2'd3;
      per_n  = per_wr ? ((wd == 0) ? 1 : wd) : m_per;
      // Poll schedule: next due edge; postponed one edge at a time while full.
      m_poll = 0;
      if (!pen_n) m_due = -1;
      else if (!m_pen || per_wr) m_due = e + per_n;
      else if (e == m_due) begin
         if (full_b) m_due = e + 1;
         else begin
            m_poll = 1;
            m_due  = e + per_n + 1;
         end
      end
      pop   = rd_acc && addr == 2'd0 && mq.size() != 0;
      flush = wr_acc && addr == 2'd2 && wd[2];
      if (flush) begin
         mq.delete();
         m_ovf = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (strb) begin
            if (!full_b || pop) mq.push_back(ch);
            else m_ovf = 1;
         end else if (wr_acc && addr == 2'd1 && wd[2]) m_ovf = 0;
         if (strb && (!full_b || pop) && wr_acc && addr == 2'd1 && wd[2]) m_ovf = 0;
      end
      if (wr_acc && addr == 2'd2) begin
         m_pen = wd[0];
         m_ien = wd[1];
      end
      m_per = per_n;
   endtask

   task automatic step(input logic rn, input logic strb, input logic [7:0] ch,
                       input logic sel, input logic [1:0] addr, input logic wr, input logic rd,
                       input logic [31:0] wd);
      resetn         = rn;
      bus.key_strobe = strb;
      bus.key_char   = ch;
      bus.reg_sel    = sel;
      bus.reg_addr   = addr;
      bus.reg_wr     = wr;
      bus.reg_rd     = rd;
      bus.reg_wdata  = wd;
      model_edge(edge_no + 1, rn, strb, ch, sel, addr, wr, rd, wd);
      @(posedge clk);
      edge_no++;
      #1;
      check("poll", 32'(bus.poll), 32'(m_poll));
      check("irq", 32'(bus.irq), 32'(m_irq));
      check("rdata", bus.reg_rdata, m_rdata);
   endtask

   task automatic idle();                          step(1, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d); step(1, 0, 0, 1, a, 1, 0, d); endtask
   task automatic strobe(input logic [7:0] c);     step(1, 1, c, 0, 0, 0, 0, 0); endtask
   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      step(1, 0, 0, 1, a, 0, 1, 0);
      check(name, bus.reg_rdata, exp);
   endtask

   initial begin
      longint w, polls[$];
      int npoll;
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("reset_poll", 32'(bus.poll), 0);
      check("reset_irq", 32'(bus.irq), 0);
      rd_chk("reset_data", 0, 0);
      rd_chk("reset_status", 1, 0);
      rd_chk("reset_ctrl", 2, 0);
      rd_chk("reset_period", 3, 12000);

      // Poll timing with PERIOD=4.
      wr(3, 4);
      wr(2, 1);
      w = edge_no;
      for (int i = 0; i < 16; i++) begin
         idle();
         if (bus.poll) polls.push_back(edge_no);
      end
      check("poll_count", 32'(polls.size()), 3);
      if (polls.size() >= 2) begin
         check("poll_first", 32'(polls[0] - w), 4);
         check("poll_space", 32'(polls[1] - polls[0]), 5);
      end
      wr(2, 0);
      npoll = 0;
      for (int i = 0; i < 12; i++) begin
         idle();
         if (bus.poll) npoll++;
      end
      check("poll_off", 32'(npoll), 0);

      // Character capture, irq latency and DATA pops.
      wr(2, 2);
      strobe(8'h41);
      check("irq_lat1", 32'(bus.irq), 0);
      strobe(8'h42);
      check("irq_lat2", 32'(bus.irq), 1);
      rd_chk("status_two", 1, 32'h201);
      rd_chk("data_41", 0, 32'h141);
      rd_chk("data_42", 0, 32'h142);
      rd_chk("data_empty", 0, 0);
      check("irq_drop", 32'(bus.irq), 0);

      // Overflow and HOLD.
      for (int i = 0; i <= DEPTH; i++) strobe(8'(8'h60 + i));
      rd_chk("status_full", 1, 32'h407);
      wr(3, 3);
      wr(2, 3);
      npoll = 0;
      for (int i = 0; i < 10; i++) begin
         idle();
         if (bus.poll) npoll++;
      end
      check("hold_no_poll", 32'(npoll), 0);
      rd_chk("data_60", 0, 32'h160);
      idle();
      check("hold_release", 32'(bus.poll), 1);
      wr(1, 4);
      rd_chk("ovf_clear", 1, 32'h301);

      // Push and pop together while full.
      strobe(8'h65);
      step(1, 1, 8'h55, 1, 0, 0, 1, 0);
      check("full_pushpop", bus.reg_rdata, 32'h161);
      rd_chk("full_no_ovf", 1, 32'h403);
      rd_chk("drain_62", 0, 32'h162);
      rd_chk("drain_63", 0, 32'h163);
      rd_chk("drain_65", 0, 32'h165);
      rd_chk("drain_55", 0, 32'h155);

      // Flush wins over a same-cycle strobe.
      strobe(8'h70);
      step(1, 1, 8'h71, 1, 2, 1, 0, 4);
      rd_chk("flush_status", 1, 0);

      // Reset in the middle of a long count.
      wr(3, 100);
      wr(2, 3);
      for (int i = 0; i < 30; i++) idle();
      strobe(8'h33);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_rdata", bus.reg_rdata, 0);
      check("rst_irq", 32'(bus.irq), 0);
      rd_chk("rst_ctrl", 2, 0);
      rd_chk("rst_period", 3, 12000);
      rd_chk("rst_status", 1, 0);
      rd_chk("rst_data", 0, 0);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         logic rn, strb, sel, wrb, rdb;
         logic [1:0] a;
         logic [31:0] d;
         rn   = ($urandom_range(0, 999) != 0);
         strb = ($urandom_range(0, 2) == 0);
         sel  = ($urandom_range(0, 3) == 0);
         a    = 2'($urandom_range(0, 3));
         wrb  = 1'($urandom_range(0, 1));
         rdb  = 1'($urandom_range(0, 1));
         case (a)
            2'd2: d = {29'b0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3) != 0};
            2'd3: d = 32'($urandom_range(0, 6));
            default: d = $urandom;
         endcase
         step(rn, strb, 8'($urandom), sel, a, wrb, rdb, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/char_in_ctrl.md
# char_in_ctrl

Controller for the character input path. It schedules poll requests to the character source at a programmable interval and queues strobed characters in a FIFO. It exposes data, status and control registers to the processor over a simple register bus and raises a level interrupt. It sits between the character source (char + strobe) and the CPU peripheral bus, so software never has to catch single-cycle strobes.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of 2, 2..256.
- DEFAULT_PERIOD, 12000: poll interval in clk cycles loaded at reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- poll  out  1  single-cycle poll request to the character source.
- key_char  in  8  character from the source; valid only when key_strobe=1.
- key_strobe  in  1  one-cycle qualifier; one character per asserted cycle.
- reg_sel  in  1  register access select.
- reg_addr  in  2  register index.
- reg_wr  in  1  write strobe; qualified by reg_sel.
- reg_rd  in  1  read strobe; qualified by reg_sel.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, registered.
- irq  out  1  level interrupt, registered.

## Operation
Registers:
- 0 DATA (RO): a read returns {23'b0, valid, char} and pops the FIFO. A read while empty returns 0 and does not pop. Writes are ignored.
- 1 STATUS: bit0 nonempty, bit1 full, bit2 overflow (sticky; write 1 to clear), bits[16:8] count (0..DEPTH). All other bits read 0.
- 2 CTRL (RW): bit0 poll_en, bit1 irq_en, bit2 flush. Flush is write-only, self-clearing and reads 0. A flush empties the FIFO and clears overflow.
- 3 PERIOD (RW, 32 bit): poll interval. A written 0 is stored as 1.

Poll scheduler FSM:
- DISABLED: counter held at 0. Moves to COUNT when poll_en=1.
- COUNT: the counter increments each cycle. When counter == PERIOD-1 and the FIFO is not full, go to POLL. If the FIFO is full at that point, go to HOLD.
- POLL: poll=1 for exactly one cycle, counter clears, then return to COUNT.
- HOLD: waits until the FIFO is not full, then goes to POLL.
- poll_en=0 from any state returns the FSM to DISABLED and clears the counter.
- A PERIOD write clears the counter. If the FSM is in POLL on that cycle, it still completes the pulse.

FIFO capture and arbitration:
- key_strobe is captured in every FSM state, including DISABLED. Capture does not depend on the poll timing.
- Push when full with no pop in the same cycle: the character is dropped and overflow is set.
- Push and pop in the same cycle when full: both take effect, count is unchanged, no overflow.
- Push and pop in the same cycle when empty: the read returns 0 and the pushed character is stored.
- Flush in the same cycle as a push: flush wins and the character is dropped; overflow is not set.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- irq = irq_en & (nonempty | overflow), registered.

## Timing
- Reset values: poll=0, reg_rdata=0, irq=0, FIFO empty, overflow=0, poll_en=0, irq_en=0, PERIOD=DEFAULT_PERIOD, FSM in DISABLED.
- A reset asserted mid-operation discards all queued data on the next edge.
- Register write takes effect at the clk edge where reg_sel & reg_wr.
- Register read: reg_rdata is valid on the cycle after reg_sel & reg_rd, and holds until the next read.
- Simultaneous reg_wr and reg_rd: the write is performed and the read returns the pre-write value.
- A captured character is visible in STATUS and DATA on the cycle after key_strobe.
- irq rises 2 cycles after key_strobe: one cycle to enqueue, one for the irq register.
- Poll latency: with poll_en written at edge N, the first poll occurs in cycle N+PERIOD. After that, poll pulses are spaced PERIOD+1 cycles apart, because the POLL cycle itself adds one.

## Test plan
- Reset, then read all registers -> DATA=0, STATUS=0, CTRL=0, PERIOD=12000, poll and irq low.
- PERIOD=4, poll_en=1 -> first poll 4 cycles after the write, then one poll every 5 cycles. Set poll_en=0 -> no further poll pulses.
- Strobe 0x41, 0x42, irq_en=1 -> irq high 2 cycles after the first strobe, STATUS count=2. DATA reads return 0x141 then 0x142. Third read returns 0 and irq drops.
- Strobe DEPTH+1 characters with no reads -> STATUS shows full, count=DEPTH, overflow=1, and the poll FSM stays in HOLD. Pop one entry -> poll is issued. Write 1 to overflow -> it clears.
- When full, strobe 0x55 in the same cycle as a DATA read -> the oldest entry is returned, 0x55 is queued last, and overflow stays 0.
- Flush coinciding with a strobe -> count=0, character dropped. Assert resetn low mid-count with PERIOD=100 -> every register is back at its reset value on the next edge.
